// File: rtl/osc_ctrl_pkg.sv
// Shared definitions for the RC/crystal clock-source controller.
// Holds the FSM state encoding and a width helper for parameter-sized counters.
package osc_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int COUNT_W = 16;

  typedef enum logic [STATE_W-1:0] {
    RC_RUN   = 3'd0,
    QUALIFY  = 3'd1,
    SW_XTL   = 3'd2,
    XTL_RUN  = 3'd3,
    SW_RC    = 3'd4,
    FALLBACK = 3'd5
  } osc_state_e;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/osc_win_meter.sv
// Crystal tick meter: counts xtl_tick pulses over a fixed window of CLK cycles
// and reports the closing count plus an in-range flag on the terminal cycle.
module osc_win_meter
  import osc_ctrl_pkg::*;
#(
  parameter int WIN_CYCLES = 1000,
  parameter int TICK_MIN   = 190,
  parameter int TICK_MAX   = 210
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               xtl_tick,
  output logic               win_done,
  output logic [COUNT_W-1:0] count,
  output logic               good
);

  localparam int WIN_W = cnt_width(WIN_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

  logic [WIN_W-1:0]   win_cnt;
  logic [COUNT_W-1:0] tick_cnt;
  logic [COUNT_W-1:0] tick_next;

  assign win_done = (win_cnt == WIN_LAST);

  // tick_next already includes a tick arriving on the closing cycle
  assign tick_next = (tick_cnt == '1) ? tick_cnt : tick_cnt + COUNT_W'(xtl_tick);

  // good is only meaningful together with win_done
  assign good = (tick_next >= COUNT_W'(TICK_MIN)) && (tick_next <= COUNT_W'(TICK_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt  <= '0;
      tick_cnt <= '0;
      count    <= '0;
    end else if (win_done) begin
      win_cnt  <= '0;
      tick_cnt <= '0;
      count    <= tick_next;
    end else begin
      win_cnt  <= win_cnt + WIN_W'(1);
      tick_cnt <= tick_next;
    end
  end

endmodule

// File: rtl/osc_source_ctrl.sv
// Clock-source controller: qualifies the crystal over several measurement
// windows, hands the clock mux over to it, and falls back to RC on failure.
module osc_source_ctrl
  import osc_ctrl_pkg::*;
#(
  parameter int WIN_CYCLES     = 1000,
  parameter int TICK_MIN       = 190,
  parameter int TICK_MAX       = 210,
  parameter int STABLE_WINDOWS = 4,
  parameter int ACK_TIMEOUT    = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               xtl_tick,
  input  logic               xtl_en_req,
  input  logic               sel_ack,
  input  logic               clr_fail,
  output logic               sel_xtl,
  output logic               using_xtl,
  output logic               xtl_fail,
  output logic [COUNT_W-1:0] win_count,
  output logic [STATE_W-1:0] state
);

  localparam int GOOD_W = cnt_width(STABLE_WINDOWS);
  localparam int TO_W   = cnt_width(ACK_TIMEOUT);
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(STABLE_WINDOWS);
  localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(ACK_TIMEOUT - 1);

  osc_state_e        cur_state;
  osc_state_e        next_state;
  logic              win_done;
  logic              win_good;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_next;
  logic [TO_W-1:0]   to_cnt;
  logic              timeout;
  logic              in_switch;
  logic              fail_set;
  logic              sel_next;
  logic              using_next;

  osc_win_meter #(
    .WIN_CYCLES (WIN_CYCLES),
    .TICK_MIN   (TICK_MIN),
    .TICK_MAX   (TICK_MAX)
  ) u_meter (
    .clk      (CLK),
    .rst      (RESET),
    .xtl_tick (xtl_tick),
    .win_done (win_done),
    .count    (win_count),
    .good     (win_good)
  );

  // Mux handshake: sel_xtl is a level request, sel_ack a level acknowledge that
  // mirrors the selection actually in force; a switch completes when they agree
  // and is abandoned if they still disagree after ACK_TIMEOUT cycles.
  assign in_switch = (cur_state == SW_XTL) || (cur_state == SW_RC) || (cur_state == FALLBACK);
  assign timeout   = (to_cnt == TO_LAST);

  always_comb begin
    good_next = good_cnt;
    if (cur_state != QUALIFY) begin
      good_next = '0;
    end else if (win_done) begin
      if (!win_good)                  good_next = '0;
      else if (good_cnt != GOOD_TARGET) good_next = good_cnt + GOOD_W'(1);
    end
  end

  // State register plus registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cur_state <= RC_RUN;
      good_cnt  <= '0;
      to_cnt    <= '0;
      xtl_fail  <= 1'b0;
      sel_xtl   <= 1'b0;
      using_xtl <= 1'b0;
    end else begin
      cur_state <= next_state;
      good_cnt  <= good_next;
      if (next_state != cur_state) to_cnt <= '0;
      else if (in_switch && !timeout) to_cnt <= to_cnt + TO_W'(1);
      xtl_fail  <= fail_set | (xtl_fail & ~clr_fail);
      sel_xtl   <= sel_next;
      using_xtl <= using_next;
    end
  end

  always_comb begin
    next_state = cur_state;
    fail_set   = 1'b0;
    case (cur_state)
      RC_RUN: begin
        if (xtl_en_req && !xtl_fail) next_state = QUALIFY;
      end
      QUALIFY: begin
        if (!xtl_en_req)                 next_state = RC_RUN;
        else if (good_next == GOOD_TARGET) next_state = SW_XTL;
      end
      SW_XTL: begin
        if (sel_ack) begin
          next_state = XTL_RUN;
        end else if (timeout) begin
          next_state = FALLBACK;
          fail_set   = 1'b1;
        end
      end
      XTL_RUN: begin
        // a failing crystal outranks a simultaneous software release
        if (win_done && !win_good) begin
          next_state = FALLBACK;
          fail_set   = 1'b1;
        end else if (!xtl_en_req) begin
          next_state = SW_RC;
        end
      end
      SW_RC: begin
        if (!sel_ack) begin
          next_state = RC_RUN;
        end else if (timeout) begin
          next_state = RC_RUN;
          fail_set   = 1'b1;
        end
      end
      FALLBACK: begin
        if (!sel_ack || timeout) next_state = RC_RUN;
      end
      default: next_state = RC_RUN;
    endcase
  end

  always_comb begin
    sel_next   = (next_state == SW_XTL) || (next_state == XTL_RUN);
    using_next = (next_state == XTL_RUN);
  end

  assign state = cur_state;

endmodule

// File: tb/tb_osc_source_ctrl.sv
// Directed bench for osc_source_ctrl: expected output records are queued by the
// stimulus and checked by a monitor whenever the observed outputs change.
module tb_osc_source_ctrl;
  import osc_ctrl_pkg::*;

  localparam int WIN  = 250;
  localparam int WIN2 = 70000;
  localparam int W    = 6;

  logic CLK = 1'b0;
  logic rst;
  logic rst2;
  logic xtl_tick, xtl_en_req, sel_ack, clr_fail;
  logic sel_xtl, using_xtl, xtl_fail;
  logic [15:0] win_count;
  logic [2:0]  state;
  logic sel_xtl2, using_xtl2, xtl_fail2;
  logic [15:0] win_count2;
  logic [2:0]  state2;

  int   pos;
  int   cyc;
  int   n_ticks;
  logic last_tick;
  logic ack_follow;
  logic ack_force;
  logic [2:0] ack_pipe;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;
  logic sat_done = 1'b0;
  int   pat [7] = '{200, 200, 220, 200, 200, 200, 200};

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  logic [W-1:0] prev_obs = '0;

  // clock / reset-driven stimulus helpers
  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      pos      <= 0;
      cyc      <= 0;
      ack_pipe <= '0;
    end else begin
      pos      <= (pos == WIN - 1) ? 0 : pos + 1;
      cyc      <= cyc + 1;
      ack_pipe <= {ack_pipe[1:0], sel_xtl};
    end
  end

  assign xtl_tick = (pos < n_ticks) || (last_tick && (pos == WIN - 1));
  assign sel_ack  = ack_follow ? ack_pipe[2] : ack_force;

  osc_source_ctrl #(
    .WIN_CYCLES (WIN)
  ) dut (
    .CLK        (CLK),
    .RESET      (rst),
    .xtl_tick   (xtl_tick),
    .xtl_en_req (xtl_en_req),
    .sel_ack    (sel_ack),
    .clr_fail   (clr_fail),
    .sel_xtl    (sel_xtl),
    .using_xtl  (using_xtl),
    .xtl_fail   (xtl_fail),
    .win_count  (win_count),
    .state      (state)
  );

  osc_source_ctrl #(
    .WIN_CYCLES (WIN2)
  ) dut_sat (
    .CLK        (CLK),
    .RESET      (rst2),
    .xtl_tick   (1'b1),
    .xtl_en_req (1'b0),
    .sel_ack    (1'b0),
    .clr_fail   (1'b0),
    .sel_xtl    (sel_xtl2),
    .using_xtl  (using_xtl2),
    .xtl_fail   (xtl_fail2),
    .win_count  (win_count2),
    .state      (state2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rec(input logic [2:0] st, input logic s, input logic u, input logic f);
    return {st, s, u, f};
  endfunction

  function automatic logic hit(input int which, input logic [2:0] val);
    case (which)
      0:       return state == val;
      1:       return sel_xtl == val[0];
      default: return using_xtl == val[0];
    endcase
  endfunction

  task automatic wait_until(input int which, input logic [2:0] val, input int budget, input string name);
    int t = 0;
    while (!hit(which, val) && t < budget) begin
      @(negedge CLK);
      t++;
    end
    if (!hit(which, val)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out after %0d cycles, state 0x%0h, required value 0x%0h", name, budget, state, val);
    end
  endtask

  task automatic wait_window();
    int t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (pos != 0 && t <= WIN + 2);
  endtask

  // scoreboard monitor
  assign obs = {state, sel_xtl, using_xtl, xtl_fail};

  always @(negedge CLK) begin
    if (mon_en && obs !== prev_obs) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_change: got 0x%0h, required no change from 0x%0h", obs, prev_obs);
      end else begin
        check("transition", 32'(obs), 32'(exp_q.pop_front()));
      end
    end
    prev_obs <= obs;
  end

  // saturation run on a long-window instance
  initial begin
    rst2 = 1'b1;
    repeat (3) @(negedge CLK);
    rst2 = 1'b0;
    repeat (WIN2 - 1) @(negedge CLK);
    check("sat_before_close", 32'(win_count2), 32'h0);
    @(negedge CLK);
    check("sat_count", 32'(win_count2), 32'hFFFF);
    check("sat_state", 32'(state2), 32'(RC_RUN));
    sat_done = 1'b1;
  end

  initial begin
    int sw_cycles;
    int t;
    rst        = 1'b1;
    xtl_en_req = 1'b0;
    clr_fail   = 1'b0;
    n_ticks    = 200;
    last_tick  = 1'b0;
    ack_follow = 1'b1;
    ack_force  = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_state", 32'(state), 32'(RC_RUN));
    check("rst_sel_xtl", 32'(sel_xtl), 32'h0);
    check("rst_using_xtl", 32'(using_xtl), 32'h0);
    check("rst_xtl_fail", 32'(xtl_fail), 32'h0);
    check("rst_win_count", 32'(win_count), 32'h0);
    mon_en = 1'b1;

    // 200 ticks/window, mux acks 3 cycles after the request
    exp_q.push_back(rec(QUALIFY, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(rec(SW_XTL,  1'b1, 1'b0, 1'b0));
    exp_q.push_back(rec(XTL_RUN, 1'b1, 1'b1, 1'b0));
    rst        = 1'b0;
    xtl_en_req = 1'b1;
    wait_until(1, 3'd1, 5 * WIN, "s1_sel_rise");
    check("s1_sel_cycle", 32'(cyc), 32'(4 * WIN));
    check("s1_win_count", 32'(win_count), 32'd200);
    wait_until(2, 3'd1, 20, "s1_using");
    check("s1_using_cycle", 32'(cyc), 32'(4 * WIN + 4));

    // crystal degrades to 150 ticks/window
    wait_window();
    n_ticks = 150;
    exp_q.push_back(rec(FALLBACK, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(rec(RC_RUN,   1'b0, 1'b0, 1'b1));
    wait_window();
    check("s2_state", 32'(state), 32'(FALLBACK));
    check("s2_fail", 32'(xtl_fail), 32'h1);
    check("s2_sel", 32'(sel_xtl), 32'h0);
    check("s2_win_count", 32'(win_count), 32'd150);
    wait_until(0, RC_RUN, 20, "s2_rc");
    check("s2_rc_cycle", 32'(cyc), 32'(6 * WIN + 4));

    // mux never acks; clr_fail collides with the timeout set
    n_ticks    = 200;
    ack_follow = 1'b0;
    ack_force  = 1'b0;
    repeat (5) @(negedge CLK);
    exp_q.push_back(rec(RC_RUN,   1'b0, 1'b0, 1'b0));
    exp_q.push_back(rec(QUALIFY,  1'b0, 1'b0, 1'b0));
    exp_q.push_back(rec(SW_XTL,   1'b1, 1'b0, 1'b0));
    exp_q.push_back(rec(FALLBACK, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(rec(RC_RUN,   1'b0, 1'b0, 1'b1));
    clr_fail = 1'b1;
    @(negedge CLK);
    clr_fail = 1'b0;
    check("s3_clr", 32'(xtl_fail), 32'h0);
    wait_until(1, 3'd1, 5 * WIN, "s3_sel_rise");
    sw_cycles = 1;
    while (state == SW_XTL && sw_cycles < 400) begin
      if (sw_cycles == 255) clr_fail = 1'b1;
      @(negedge CLK);
      clr_fail = 1'b0;
      if (state == SW_XTL) sw_cycles++;
    end
    check("s3_sw_cycles", 32'(sw_cycles), 32'd255);
    check("s3_state", 32'(state), 32'(FALLBACK));
    check("s3_fail_collision", 32'(xtl_fail), 32'h1);
    wait_until(0, RC_RUN, 10, "s3_rc");

    // good, good, bad(220), then four good windows
    ack_follow = 1'b1;
    wait_window();
    @(negedge CLK);
    exp_q.push_back(rec(RC_RUN,  1'b0, 1'b0, 1'b0));
    exp_q.push_back(rec(QUALIFY, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(rec(SW_XTL,  1'b1, 1'b0, 1'b0));
    exp_q.push_back(rec(XTL_RUN, 1'b1, 1'b1, 1'b0));
    clr_fail = 1'b1;
    @(negedge CLK);
    clr_fail = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_ticks = pat[i];
      wait_window();
      check($sformatf("s4_sel_w%0d", i), 32'(sel_xtl), (i == 6) ? 32'h1 : 32'h0);
      if (i == 2) check("s4_bad_count", 32'(win_count), 32'd220);
    end
    wait_until(2, 3'd1, 20, "s4_using");

    // coincident tick and range boundaries while running on the crystal
    wait_window();
    n_ticks   = 199;
    last_tick = 1'b1;
    wait_window();
    check("s5_coincident", 32'(win_count), 32'd200);
    n_ticks   = 190;
    last_tick = 1'b0;
    wait_window();
    check("s5_min_count", 32'(win_count), 32'd190);
    check("s5_min_state", 32'(state), 32'(XTL_RUN));
    n_ticks   = 209;
    last_tick = 1'b1;
    wait_window();
    check("s5_max_count", 32'(win_count), 32'd210);
    check("s5_max_state", 32'(state), 32'(XTL_RUN));
    n_ticks   = 200;
    last_tick = 1'b0;
    exp_q.push_back(rec(SW_RC,  1'b0, 1'b0, 1'b0));
    exp_q.push_back(rec(RC_RUN, 1'b0, 1'b0, 1'b0));
    xtl_en_req = 1'b0;
    wait_until(0, RC_RUN, 20, "s5_release");
    check("s5_no_fail", 32'(xtl_fail), 32'h0);

    // asynchronous reset in the middle of a switch
    ack_follow = 1'b0;
    ack_force  = 1'b0;
    exp_q.push_back(rec(QUALIFY, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(rec(SW_XTL,  1'b1, 1'b0, 1'b0));
    xtl_en_req = 1'b1;
    wait_until(1, 3'd1, 5 * WIN, "s6_sel_rise");
    repeat (10) @(negedge CLK);
    exp_q.push_back(rec(RC_RUN, 1'b0, 1'b0, 1'b0));
    #2 rst = 1'b1;
    #1;
    check("s6_async_sel", 32'(sel_xtl), 32'h0);
    check("s6_async_state", 32'(state), 32'(RC_RUN));
    check("s6_async_win_count", 32'(win_count), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    exp_q.push_back(rec(QUALIFY, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    repeat (WIN - 1) @(negedge CLK);
    check("s6_window_open", 32'(win_count), 32'h0);
    @(negedge CLK);
    check("s6_window_close", 32'(win_count), 32'd200);
    exp_q.push_back(rec(RC_RUN, 1'b0, 1'b0, 1'b0));
    xtl_en_req = 1'b0;
    repeat (5) @(negedge CLK);

    t = 0;
    while (!sat_done && t < 80000) begin
      @(negedge CLK);
      t++;
    end
    if (!sat_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL sat_timeout: got no window close, required one within %0d cycles", 80000);
    end
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
